shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit enabled storage register (D flip-flop bank with enable) between N requesters. Each cycle it selects at most one requester, drives that requester's data into the register and returns a one-hot grant. A requester may lock the register for back-to-back writes, bounded by a lock timeout. The block sits between requesting agents and the shared register stage and owns that register's enable.

## Interface
- N, default 4: number of requesters, 2..8.
- WIDTH, default 8: register data width.
- MAX_LOCK, default 8: maximum consecutive cycles one owner may hold the lock, 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req  input  N  per-requester write request; held until granted.
- lock  input  N  per-requester lock request; sampled only on a grant to that requester.
- wdata  input  N*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  output  N  combinational one-hot grant; a write occurs on the rising edge where gnt[i]=1.
- q  output  WIDTH  shared register contents.
- upd  output  1  registered; 1 for exactly one cycle after each write.
- owned  output  1  registered; 1 while in state OWNED.
- owner  output  $clog2(N)  registered; index of the current lock owner (0 when not owned).

## Operation
- Reset (rst=0) sets q=0, upd=0, owned=0, owner=0, ptr=0 and lock_cnt=0, with state IDLE. gnt is forced to 0 while rst=0.
- ptr is the round-robin start index.

State IDLE:
- Winner is the first i with req[i]=1, searching ptr, ptr+1, …, N-1, 0, … (mod N).
- Drive gnt[winner]=1. At the edge: q <= wdata slice of winner, upd <= 1, ptr <= (winner+1) mod N.
- If lock[winner]=1 at that edge: go to OWNED with owner <= winner and lock_cnt <= 1.
- No req: gnt=0, q holds, upd <= 0.

State OWNED:
- Only the owner can be granted. gnt[owner]=req[owner], and other requests wait.
- On each edge in OWNED, lock_cnt increments, saturating at MAX_LOCK.
- Exit to IDLE on the first edge where lock[owner]=0, or where lock_cnt=MAX_LOCK (timeout).
  - owned <= 0 and owner <= 0 on exit.
  - ptr <= (owner+1) mod N.
- A write on the exit edge still completes. It is the owner's final write.
- Requests from other requesters are not sampled until the cycle after exit.
- q changes only on a granted edge; no grant means q holds its value (register enable low).
- gnt is never multi-hot and never asserted for i with req[i]=0.

## Timing
- Grant is zero-latency (combinational from req, lock, state and ptr). Register write latency is 1: q is valid after the granting edge.
- upd is asserted the cycle after the write, concurrent with the new q.
- owned/owner update on the edge that accepts a locked grant, so owned=1 from the next cycle.
- Requester handshake: hold req and wdata stable until the edge with gnt=1. Deasserting req before that edge withdraws the request with no write.
- Keeping req high after a grant issues a new request. In IDLE it competes from the updated ptr, so with two or more continuous requesters no requester waits more than N-1 grants.
- Async reset mid-operation (including in OWNED) clears everything immediately, not at an edge. First grant is possible in the first cycle after rst deasserts.
- MAX_LOCK=1: locked grant enters OWNED, then timeout forces exit on the next edge. At most 2 consecutive owner writes.

## Test plan
- Reset: drive rst=0 with req=4'b1111 and wdata all 8'hFF; mid-cycle assert of rst -> q=0, gnt=0, upd=0, owned=0 immediately and held while rst=0.
- Single requester: req=4'b0100, wdata[2]=8'hA5, lock=0 -> gnt=4'b0100 that cycle; q=8'hA5 and upd=1 next cycle; ptr=3.
- Round robin: req=4'b1111 held 8 cycles, data i=8'h10+i -> grants in order 0,1,2,3,0,1,2,3; q follows 8'h10,11,12,13,…
- Lock release: req1 lock=1 for 3 writes, then lock=0; req0 held throughout -> gnt=4'b0010 for 4 edges, gnt[0]=0 meanwhile; req0 granted the cycle after the owner releases.
- Lock timeout: MAX_LOCK=8, req2 and lock2 held, req3 held -> owner 2 receives grants through the edge where lock_cnt=8, then owned=0 and the next grant goes to requester 3.
- Withdrawal and idle: req0 pulses while OWNED by 1 and drops before release -> no write from 0. req=0 for 5 cycles -> q unchanged, upd=0.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that owns the enable of one shared WIDTH-bit register.
// A granted requester may lock the register for back-to-back writes, bounded by MAX_LOCK.
module shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 8,
    localparam int IdxW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    input  logic [N*WIDTH-1:0]   wdata,
    output logic [N-1:0]         gnt,
    output logic [WIDTH-1:0]     q,
    output logic                 upd,
    output logic                 owned,
    output logic [IdxW-1:0]      owner
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t            state_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   owner_q;
    logic              owned_q;
    logic [7:0]        lockCnt_q;
    logic [WIDTH-1:0]  data_q;
    logic              upd_q;

    logic              found;
    logic [IdxW-1:0]   winnerIdx;
    logic [IdxW-1:0]   grantIdx;
    logic              grantValid;
    logic [N-1:0]      gntRaw;
    logic [WIDTH-1:0]  writeData;
    logic              lockExit;

    function automatic logic [IdxW-1:0] nextIdx(input logic [IdxW-1:0] i);
        return IdxW'((int'(i) + 1) % N);
    endfunction

    // Rotating priority search starting at ptr; in OWNED only the owner may write.
    always_comb begin
        int idx;
        idx        = 0;
        found      = 1'b0;
        winnerIdx  = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found     = 1'b1;
                winnerIdx = IdxW'(idx);
            end
        end
        gntRaw     = '0;
        grantValid = 1'b0;
        grantIdx   = winnerIdx;
        if (state_q == IDLE) begin
            if (found) begin
                gntRaw[winnerIdx] = 1'b1;
                grantValid        = 1'b1;
            end
        end else begin
            grantIdx = owner_q;
            if (req[owner_q]) begin
                gntRaw[owner_q] = 1'b1;
                grantValid      = 1'b1;
            end
        end
    end

    assign writeData = wdata[int'(grantIdx)*WIDTH +: WIDTH];
    assign lockExit  = !lock[owner_q] || (lockCnt_q == 8'(MAX_LOCK));
    assign gnt       = rst ? gntRaw : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            owned_q   <= 1'b0;
            lockCnt_q <= '0;
            data_q    <= '0;
            upd_q     <= 1'b0;
        end else begin
            upd_q <= grantValid;
            if (grantValid) begin
                data_q <= writeData;
            end
            case (state_q)
                IDLE: begin
                    if (found) begin
                        ptr_q <= nextIdx(winnerIdx);
                        if (lock[winnerIdx]) begin
                            state_q   <= OWNED;
                            owned_q   <= 1'b1;
                            owner_q   <= winnerIdx;
                            lockCnt_q <= 8'd1;
                        end
                    end
                end
                OWNED: begin
                    // Release or timeout; a write on this same edge is the owner's last.
                    if (lockExit) begin
                        state_q   <= IDLE;
                        owned_q   <= 1'b0;
                        owner_q   <= '0;
                        ptr_q     <= nextIdx(owner_q);
                        lockCnt_q <= '0;
                    end else begin
                        lockCnt_q <= lockCnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q     = data_q;
    assign upd   = upd_q;
    assign owned = owned_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (N=4, WIDTH=8, MAX_LOCK=8) with hand-computed expectations.
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        upd;
    logic        owned;
    logic [1:0]  owner;

    int checks   = 0;
    int failures = 0;

    shared_reg_arbiter #(.N(4), .WIDTH(8), .MAX_LOCK(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .q     (q),
        .upd   (upd),
        .owned (owned),
        .owner (owner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setData(input int idx, input logic [7:0] value);
        wdata[idx*8 +: 8] = value;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b1111;
        lock  = 4'b0000;
        wdata = 32'hFFFF_FFFF;

        // Asynchronous reset asserted between edges takes effect immediately.
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_q", 32'(q), 32'h00);
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_upd", 32'(upd), 32'h0);
        checkOutput("rst_owned", 32'(owned), 32'h0);
        tick();
        tick();
        checkOutput("rst_hold_q", 32'(q), 32'h00);
        checkOutput("rst_hold_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_hold_upd", 32'(upd), 32'h0);
        req = 4'b0000;
        #3 rst = 1'b1;
        tick();

        // Single requester, then ptr=3 shown by 3 beating 0.
        req  = 4'b0100;
        setData(2, 8'hA5);
        #1 checkOutput("single_gnt", 32'(gnt), 32'h4);
        tick();
        req = 4'b0000;
        checkOutput("single_q", 32'(q), 32'hA5);
        checkOutput("single_upd", 32'(upd), 32'h1);
        checkOutput("single_owned", 32'(owned), 32'h0);
        req = 4'b1001;
        setData(3, 8'h3C);
        setData(0, 8'h0C);
        #1 checkOutput("ptr3_gnt", 32'(gnt), 32'h8);
        tick();
        req = 4'b0000;
        checkOutput("ptr3_q", 32'(q), 32'h3C);

        // Round robin from ptr=0 with all four requesting.
        for (int i = 0; i < 4; i++) setData(i, 8'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 checkOutput($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            tick();
            checkOutput($sformatf("rr_q%0d", k), 32'(q), 32'(8'h10 + (k % 4)));
            checkOutput($sformatf("rr_upd%0d", k), 32'(upd), 32'h1);
        end

        // Idle: no requests, q holds.
        req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            #1 checkOutput($sformatf("idle_gnt%0d", k), 32'(gnt), 32'h0);
            tick();
            checkOutput($sformatf("idle_q%0d", k), 32'(q), 32'h13);
            checkOutput($sformatf("idle_upd%0d", k), 32'(upd), 32'h0);
        end

        // Move ptr to 1 so requester 1 wins against a waiting requester 0.
        req = 4'b0001;
        setData(0, 8'h20);
        tick();
        checkOutput("pre_lock_q", 32'(q), 32'h20);

        // Lock release: requester 1 locks for three writes, releases on the fourth.
        req = 4'b0011;
        setData(0, 8'h40);
        for (int k = 1; k <= 4; k++) begin
            lock = (k < 4) ? 4'b0010 : 4'b0000;
            setData(1, 8'(8'h30 + k));
            #1 checkOutput($sformatf("lk_gnt%0d", k), 32'(gnt), 32'h2);
            tick();
            checkOutput($sformatf("lk_q%0d", k), 32'(q), 32'(8'h30 + k));
            checkOutput($sformatf("lk_owned%0d", k), 32'(owned), (k < 4) ? 32'h1 : 32'h0);
            checkOutput($sformatf("lk_owner%0d", k), 32'(owner), (k < 4) ? 32'h1 : 32'h0);
        end
        #1 checkOutput("lk_after_gnt", 32'(gnt), 32'h1);
        tick();
        req = 4'b0000;
        checkOutput("lk_after_q", 32'(q), 32'h40);

        // Withdrawal: requester 0 pulses while 1 owns but is idle.
        req  = 4'b0010;
        lock = 4'b0010;
        setData(1, 8'h50);
        tick();
        checkOutput("wd_owned", 32'(owned), 32'h1);
        req = 4'b0001;
        setData(0, 8'h66);
        #1 checkOutput("wd_gnt", 32'(gnt), 32'h0);
        tick();
        checkOutput("wd_q", 32'(q), 32'h50);
        checkOutput("wd_upd", 32'(upd), 32'h0);
        req  = 4'b0010;
        lock = 4'b0000;
        setData(1, 8'h51);
        #1 checkOutput("wd_rel_gnt", 32'(gnt), 32'h2);
        tick();
        checkOutput("wd_rel_owned", 32'(owned), 32'h0);
        req = 4'b0000;
        #1 checkOutput("wd_idle_gnt", 32'(gnt), 32'h0);
        tick();
        checkOutput("wd_idle_q", 32'(q), 32'h51);
        checkOutput("wd_idle_upd", 32'(upd), 32'h0);

        // Timeout: owner 2 gets entry write plus 8 owned writes, then 3 is served.
        req  = 4'b1100;
        lock = 4'b0100;
        setData(3, 8'h99);
        for (int k = 0; k <= 8; k++) begin
            setData(2, 8'(8'h70 + k));
            #1 checkOutput($sformatf("to_gnt%0d", k), 32'(gnt), 32'h4);
            tick();
            checkOutput($sformatf("to_q%0d", k), 32'(q), 32'(8'h70 + k));
            checkOutput($sformatf("to_owned%0d", k), 32'(owned), (k < 8) ? 32'h1 : 32'h0);
        end
        req  = 4'b1000;
        lock = 4'b0000;
        #1 checkOutput("to_next_gnt", 32'(gnt), 32'h8);
        tick();
        req = 4'b0000;
        checkOutput("to_next_q", 32'(q), 32'h99);

        // Async reset while OWNED, then first grant right after release.
        req  = 4'b0010;
        lock = 4'b0010;
        setData(1, 8'hAB);
        tick();
        checkOutput("mr_owned_pre", 32'(owned), 32'h1);
        checkOutput("mr_q_pre", 32'(q), 32'hAB);
        req   = 4'b1111;
        wdata = 32'hFFFF_FFFF;
        #2 rst = 1'b0;
        #1;
        checkOutput("mr_q", 32'(q), 32'h00);
        checkOutput("mr_owned", 32'(owned), 32'h0);
        checkOutput("mr_owner", 32'(owner), 32'h0);
        checkOutput("mr_gnt", 32'(gnt), 32'h0);
        checkOutput("mr_upd", 32'(upd), 32'h0);
        tick();
        checkOutput("mr_hold_q", 32'(q), 32'h00);
        lock = 4'b0000;
        #3 rst = 1'b1;
        #1 checkOutput("mr_first_gnt", 32'(gnt), 32'h1);
        tick();
        checkOutput("mr_first_q", 32'(q), 32'hFF);
        checkOutput("mr_first_upd", 32'(upd), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
